// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
// Multiplies operand magnitudes over 32 cycles, then applies the sign fix-up.
module mul_seq_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic        start,
  input  logic [2:0]  funct3,
  output logic        mul_done,
  output logic        busy,
  output logic [31:0] product
);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state, state_next;
  logic [64:0] acc;
  logic [31:0] mcand;
  logic [5:0]  count;
  logic        neg;
  logic [2:0]  f3_q;

  logic        is_mul_req, zero_op, load;
  logic        sign1, sign2;
  logic [31:0] mag1, mag2;
  logic [32:0] sum;
  logic [63:0] p_final;

  assign is_mul_req = start && (funct3[2] == 1'b0);
  assign zero_op    = (multiplicand == 32'd0) || (multiplier == 32'd0);
  assign sign1      = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) && multiplicand[31];
  assign sign2      = (funct3 == F3_MULH) && multiplier[31];
  assign mag1       = sign1 ? (~multiplicand + 32'd1) : multiplicand;
  assign mag2       = sign2 ? (~multiplier + 32'd1) : multiplier;

  // c is always zero entering an iteration, so {c,hi} is the 33-bit addend base
  assign sum     = acc[64:32] + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign p_final = neg ? (~acc[63:0] + 64'd1) : acc[63:0];
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_next = state;
    mul_done   = 1'b0;
    product    = 32'd0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mul_req) begin
          if (zero_op) begin
            mul_done = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (count == 6'd1) state_next = S_DONE;
      end
      S_DONE: begin
        mul_done   = 1'b1;
        product    = (f3_q == F3_MUL) ? p_final[31:0] : p_final[63:32];
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= 65'd0;
      mcand <= 32'd0;
      count <= 6'd0;
      neg   <= 1'b0;
      f3_q  <= 3'd0;
    end else begin
      state <= state_next;
      if (load) begin
        acc   <= {33'd0, mag2};
        mcand <= mag1;
        count <= 6'd32;
        neg   <= sign1 ^ sign2;
        f3_q  <= funct3;
      end else if (state == S_CALC) begin
        acc   <= {1'b0, sum, acc[31:1]};
        count <= count - 6'd1;
      end
    end
  end

endmodule
